// File: rtl/pipelined_cpa.sv
// -----------------------------------------------------------------------------
// pipelined_cpa
//   Pipelined carry-propagate adder/subtractor. The WIDTH-bit operands are cut
//   into STAGES equal slices. Each register stage resolves one slice with a
//   ripple generate/propagate chain and passes the carry to the next stage.
//   The upper operand slices ride along, skewed, until their stage is reached.
//   A beat accepted on clock edge t is visible at the outputs after edge
//   t+STAGES-1, which is STAGES register stages in total. With STAGES=1 this
//   degenerates to one registered ripple adder.
//
//   Handshake: stage k loads whenever it is empty or its successor loads.
//   out_ready therefore ripples combinationally back to in_ready, and empty
//   stages (bubbles) are filled even while the output is stalled.
//
//   Optional build macro CPA_SATURATE_EN: on signed overflow the result is
//   clamped to the signed max/min chosen by the sign of a. cout and ovf are
//   still reported unmodified. Without the macro the sum wraps modulo
//   2^WIDTH.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth and slice count (1..WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   a, b       operands
//   cin        carry in (add mode only)
//   sub        0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result
//   cout       unsigned carry out of the MSB (sub mode: 1 = no borrow)
//   ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_cpa #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Ripple one slice. The result is packed as
  // {carry out, carry into slice MSB, slice sum}.
  // The carry into the MSB is kept so that the last stage can form ovf.
  function automatic logic [SLICE+1:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             ci
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
  endfunction

  // Stage registers. Stage k holds:
  //   result slices 0..k in res_r,
  //   still-pending operand slices k+1.. in a_r and bx_r,
  //   the carry out of slice k in c_r.
  // The last stage is the output register.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  bx_r  [STAGES];
  logic [WIDTH-1:0]  res_r [STAGES];
  logic              ovf_r;

  // Per-stage load enables and the next values presented to each stage.
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] xv;
  logic [STAGES-1:0] nc;
  logic [WIDTH-1:0]  xa   [STAGES];
  logic [WIDTH-1:0]  xb   [STAGES];
  logic [WIDTH-1:0]  nres [STAGES];
  logic              novf;

  // Load enables are chained from the output back to the input. The chain
  // depends only on the valid bits and out_ready, never on in_valid.
  always_comb begin : handshake
    logic down;
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so that no path can leave it unassigned and infer a latch.
    ld   = '0;
    down = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = ~v[k] | down;
      down  = ld[k];
    end
  end

  assign in_ready = ld[0];

  always_comb begin : datapath
    logic             xc;
    logic [WIDTH-1:0] xr;
    logic [SLICE+1:0] t;
    xv   = '0;
    nc   = '0;
    novf = 1'b0;
    xc   = 1'b0;
    xr   = '0;
    t    = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Operand conditioning happens once, at acceptance.
        xv[k] = in_valid;
        xa[k] = a;
        xb[k] = sub ? ~b : b;
        xc    = sub | cin;
        xr    = '0;
      end else begin
        xv[k] = v[k-1];
        xa[k] = a_r[k-1];
        xb[k] = bx_r[k-1];
        xc    = c_r[k-1];
        xr    = res_r[k-1];
      end
      t       = slice_add(xa[k][k*SLICE +: SLICE], xb[k][k*SLICE +: SLICE], xc);
      nres[k] = xr;
      nres[k][k*SLICE +: SLICE] = t[SLICE-1:0];
      nc[k]   = t[SLICE+1];
      if (k == STAGES - 1) begin
        novf = t[SLICE+1] ^ t[SLICE];
      end
    end
`ifdef CPA_SATURATE_EN
    // Clamp in the final stage only, so that latency is unchanged.
    if (novf) begin
      nres[STAGES-1] = xa[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data registers are reset together with the valid bits.
      // The output register must read zero after reset, and clearing the rest
      // keeps every stage free of X without any special cases.
      v     <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        bx_r[k]  <= '0;
        res_r[k] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Each stage
      // then reads its predecessor's pre-edge value.
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= xv[k];
          // A bubble moves in without disturbing data, so an idle output
          // keeps its last result.
          if (xv[k]) begin
            c_r[k]   <= nc[k];
            a_r[k]   <= xa[k];
            bx_r[k]  <= xb[k];
            res_r[k] <= nres[k];
          end
        end
      end
      if (ld[STAGES-1] && xv[STAGES-1]) begin
        ovf_r <= novf;
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign sum       = res_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign ovf       = ovf_r;

endmodule
